// File: rtl/req_onehot_arbiter.sv
// Request arbiter feeding the 4-to-2 encoder.
// Synchronised edge capture, one-hot grant out.
module req_onehot_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter bit RR_MODE     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic       y3,
  output logic       y2,
  output logic       y1,
  output logic       y0,
  output logic       out_valid,
  output logic [3:0] pending,
  output logic [3:0] overrun
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] prev_q;
  logic [3:0] pending_q;
  logic [3:0] overrun_q;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;

  logic [3:0] sync_o;
  logic [3:0] rise;
  logic       accept;
  logic [3:0] clr;
  logic [3:0] ovr_set;
  logic [1:0] sel_idx;
  logic [1:0] idx;
  logic       found;

  assign sync_o  = sync_q[SYNC_STAGES-1];
  assign rise    = sync_o & ~prev_q;
  assign accept  = (state_q == GRANT) & out_ready;
  assign clr     = accept ? grant_q : 4'b0000;
  assign ovr_set = rise & pending_q & ~clr;

  // Synchroniser chains and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      prev_q <= sync_o;
    end
  end

  // Pending events: a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
      overrun_q <= (ovr_clr ? 4'b0000 : overrun_q) | ovr_set;
    end
  end

  // Line selection: fixed (highest wins) or round-robin
  always_comb begin
    sel_idx = '0;
    idx     = '0;
    found   = 1'b0;
    if (RR_MODE) begin
      for (int k = 1; k <= 4; k++) begin
        idx = last_q + 2'(k);
        if (!found && pending_q[idx]) begin
          sel_idx = idx;
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pending_q[i]) sel_idx = 2'(i);
      end
    end
  end

  // Grant FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Grant FSM next state: load in IDLE, hold until accept
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = GRANT;
          grant_d = 4'b0001 << sel_idx;
          last_d  = sel_idx;
        end
      end
      GRANT: begin
        if (out_ready) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign {y3, y2, y1, y0} = grant_q;
  assign out_valid        = (state_q == GRANT);
  assign pending          = pending_q;
  assign overrun          = overrun_q;

endmodule
